tri_scan_ctrl: RTL and testbench

- Initiator side of the point-in-triangle query interface; drives the responder that evaluates whether P lies inside triangle ABC.
- Latches triangle vertices A, B, C on start and computes the clipped bounding box.
- Raster-scans every pixel P in the box, row-major, issuing one query per pixel with a valid/ready handshake and waiting for the inside/outside result.
- Forwards each result as a pixel write (x, y, on) to the frame-buffer writer under backpressure.

---
 rtl/tri_scan_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_tri_scan_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_scan_ctrl.sv
// Initiator for point-in-triangle queries. It latches a triangle and computes its screen-clipped
// bounding box. It then raster-scans the box with one query per pixel and forwards each result as a pixel write.
module tri_scan_ctrl #(
    parameter int unsigned XW      = 11,
    parameter int unsigned YW      = 10,
    parameter int unsigned XMAX    = 639,
    parameter int unsigned YMAX    = 479,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] ax,
    input  logic [XW-1:0] bx,
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] ay,
    input  logic [YW-1:0] by,
    input  logic [YW-1:0] cy,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          qry_valid,
    input  logic          qry_ready,
    output logic [XW-1:0] qry_px,
    output logic [YW-1:0] qry_py,
    input  logic          res_valid,
    input  logic          res_inside,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_on
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BBOX,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_STEP,
        S_DONE
    } state_e;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [XW-1:0] XLIM  = XW'(XMAX);
    localparam logic [YW-1:0] YLIM  = YW'(YMAX);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] ax_q, bx_q, cx_q, ax_d, bx_d, cx_d;
    logic [YW-1:0] ay_q, by_q, cy_q, ay_d, by_d, cy_d;
    logic [XW-1:0] xmin_q, xmax_q, xmin_d, xmax_d;
    logic [YW-1:0] ymin_q, ymax_q, ymin_d, ymax_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;
    logic          err_q, err_d;

    logic [XW-1:0] bb_xmin, bb_xmax;
    logic [YW-1:0] bb_ymin, bb_ymax;

    function automatic logic [XW-1:0] min3x(input logic [XW-1:0] a, b, c);
        logic [XW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [XW-1:0] max3x(input logic [XW-1:0] a, b, c);
        logic [XW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [YW-1:0] min3y(input logic [YW-1:0] a, b, c);
        logic [YW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [YW-1:0] max3y(input logic [YW-1:0] a, b, c);
        logic [YW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [XW-1:0] clipx(input logic [XW-1:0] v);
        return (v > XLIM) ? XLIM : v;
    endfunction

    function automatic logic [YW-1:0] clipy(input logic [YW-1:0] v);
        return (v > YLIM) ? YLIM : v;
    endfunction

    // Both ends of the box are clipped, so an off-screen triangle collapses onto the screen edge.
    assign bb_xmin = clipx(min3x(ax_q, bx_q, cx_q));
    assign bb_xmax = clipx(max3x(ax_q, bx_q, cx_q));
    assign bb_ymin = clipy(min3y(ay_q, by_q, cy_q));
    assign bb_ymax = clipy(max3y(ay_q, by_q, cy_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ax_q    <= '0;
            bx_q    <= '0;
            cx_q    <= '0;
            ay_q    <= '0;
            by_q    <= '0;
            cy_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            cnt_q   <= '0;
            on_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            bx_q    <= bx_d;
            cx_q    <= cx_d;
            ay_q    <= ay_d;
            by_q    <= by_d;
            cy_q    <= cy_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            px_q    <= px_d;
            py_q    <= py_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        bx_d    = bx_q;
        cx_d    = cx_q;
        ay_d    = ay_q;
        by_d    = by_q;
        cy_d    = cy_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        px_d    = px_q;
        py_d    = py_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ax_d    = ax;
                    bx_d    = bx;
                    cx_d    = cx;
                    ay_d    = ay;
                    by_d    = by;
                    cy_d    = cy;
                    err_d   = 1'b0;
                    state_d = S_BBOX;
                end
            end
            S_BBOX: begin
                xmin_d  = bb_xmin;
                xmax_d  = bb_xmax;
                ymin_d  = bb_ymin;
                ymax_d  = bb_ymax;
                px_d    = bb_xmin;
                py_d    = bb_ymin;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (qry_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the last counted cycle still beats the timeout.
                if (res_valid) begin
                    on_d    = res_inside;
                    state_d = S_EMIT;
                end else if (cnt_q == TLAST) begin
                    on_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (px_q == xmax_q && py_q == ymax_q) begin
                    state_d = S_DONE;
                end else if (px_q == xmax_q) begin
                    px_d    = xmin_q;
                    py_d    = py_q + YW'(1);
                    state_d = S_ISSUE;
                end else begin
                    px_d    = px_q + XW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode straight from registers, so an asynchronous reset clears them at once.
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign qry_valid = (state_q == S_ISSUE);
    assign qry_px    = px_q;
    assign qry_py    = py_q;
    assign pix_valid = (state_q == S_EMIT);
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_on    = on_q;

endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Directed bench for tri_scan_ctrl: a modelled responder and frame-buffer sink, with configurable stalls.
// Scans are checked against a bench-side edge-function triangle model.
module tb_tri_scan_ctrl;

    localparam int XW = 11;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [XW-1:0] ax = '0, bx = '0, cx = '0;
    logic [YW-1:0] ay = '0, by = '0, cy = '0;
    logic          busy, done, err;
    logic          qry_valid;
    logic          qry_ready = 1'b0;
    logic [XW-1:0] qry_px;
    logic [YW-1:0] qry_py;
    logic          res_valid = 1'b0;
    logic          res_inside = 1'b0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_on;

    always #5 clk = ~clk;

    tri_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ax        (ax),
        .bx        (bx),
        .cx        (cx),
        .ay        (ay),
        .by        (by),
        .cy        (cy),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .qry_valid (qry_valid),
        .qry_ready (qry_ready),
        .qry_px    (qry_px),
        .qry_py    (qry_py),
        .res_valid (res_valid),
        .res_inside(res_inside),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_on    (pix_on)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Triangle used by the responder model, plus the optional silenced query point
    int triAx = 0, triAy = 0, triBx = 0, triBy = 0, triCx = 0, triCy = 0;
    bit dropEn = 1'b0;
    int dropX = 0, dropY = 0;
    int qStall = 0, pStall = 0;

    bit respArmed = 1'b0;
    int respX = 0, respY = 0;

    int qryX[$], qryY[$], pixX[$], pixY[$];
    bit pixOn[$];
    int doneCount = 0, doneCyc = 0;
    int stallChecks = 0, stallErrors = 0;
    int expX[$], expY[$];
    bit expOn[$];

    function automatic bit insideTri(int x, int y, int ax0, int ay0, int bx0, int by0, int cx0, int cy0);
        longint e0, e1, e2;
        e0 = longint'(bx0 - ax0) * (y - ay0) - longint'(by0 - ay0) * (x - ax0);
        e1 = longint'(cx0 - bx0) * (y - by0) - longint'(cy0 - by0) * (x - bx0);
        e2 = longint'(ax0 - cx0) * (y - cy0) - longint'(ay0 - cy0) * (x - cx0);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // Monitor: record handshakes and done pulses, and check outputs hold while stalled
    initial begin
        bit qHeld, pHeld, pHeldOn;
        int qHeldX, qHeldY, pHeldX, pHeldY;
        qHeld = 1'b0;
        pHeld = 1'b0;
        pHeldOn = 1'b0;
        qHeldX = 0; qHeldY = 0; pHeldX = 0; pHeldY = 0;
        forever begin
            @(negedge clk);
            if (qry_valid && qry_ready) begin
                qryX.push_back(int'(qry_px));
                qryY.push_back(int'(qry_py));
            end
            if (pix_valid && pix_ready) begin
                pixX.push_back(int'(pix_x));
                pixY.push_back(int'(pix_y));
                pixOn.push_back(pix_on);
            end
            if (done === 1'b1) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (qHeld) begin
                stallChecks++;
                if (!(qry_valid === 1'b1 && int'(qry_px) == qHeldX && int'(qry_py) == qHeldY))
                    stallErrors++;
            end
            if (pHeld) begin
                stallChecks++;
                if (!(pix_valid === 1'b1 && int'(pix_x) == pHeldX && int'(pix_y) == pHeldY && pix_on === pHeldOn))
                    stallErrors++;
            end
            qHeld = qry_valid && !qry_ready;
            qHeldX = int'(qry_px);
            qHeldY = int'(qry_py);
            pHeld = pix_valid && !pix_ready;
            pHeldX = int'(pix_x);
            pHeldY = int'(pix_y);
            pHeldOn = pix_on;
            respArmed = qry_valid && qry_ready;
            respX = int'(qry_px);
            respY = int'(qry_py);
        end
    end

    // Responder: one-cycle result pulse in the cycle after each accepted query
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (respArmed && !(dropEn && respX == dropX && respY == dropY)) begin
                res_valid = 1'b1;
                res_inside = insideTri(respX, respY, triAx, triAy, triBx, triBy, triCx, triCy);
            end else begin
                res_valid = 1'b0;
                res_inside = 1'b0;
            end
        end
    end

    // Ready drivers: hold each ready low for the configured number of cycles per transaction
    initial begin
        int qWait, pWait;
        qWait = 0;
        pWait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (qry_valid) begin
                qry_ready = (qWait >= qStall);
                qWait++;
            end else begin
                qWait = 0;
                qry_ready = (qStall == 0);
            end
            if (pix_valid) begin
                pix_ready = (pWait >= pStall);
                pWait++;
            end else begin
                pWait = 0;
                pix_ready = (pStall == 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ax0, input int ay0, input int bx0, input int by0,
                                 input int cx0, input int cy0, output int startCyc);
        @(posedge clk);
        #1;
        triAx = ax0; triAy = ay0; triBx = bx0; triBy = by0; triCx = cx0; triCy = cy0;
        ax = XW'(ax0); ay = YW'(ay0);
        bx = XW'(bx0); by = YW'(by0);
        cx = XW'(cx0); cy = YW'(cy0);
        start = 1'b1;
        @(negedge clk);
        startCyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        ax = '1; ay = '1; bx = '1; by = '1; cx = '1; cy = '1;
    endtask

    task automatic buildExpected();
        int xmin, xmax, ymin, ymax;
        expX.delete();
        expY.delete();
        expOn.delete();
        xmin = (triAx < triBx) ? triAx : triBx;  xmin = (xmin < triCx) ? xmin : triCx;
        xmax = (triAx > triBx) ? triAx : triBx;  xmax = (xmax > triCx) ? xmax : triCx;
        ymin = (triAy < triBy) ? triAy : triBy;  ymin = (ymin < triCy) ? ymin : triCy;
        ymax = (triAy > triBy) ? triAy : triBy;  ymax = (ymax > triCy) ? ymax : triCy;
        if (xmin > 639) xmin = 639;
        if (xmax > 639) xmax = 639;
        if (ymin > 479) ymin = 479;
        if (ymax > 479) ymax = 479;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                expX.push_back(x);
                expY.push_back(y);
                if (dropEn && x == dropX && y == dropY)
                    expOn.push_back(1'b0);
                else
                    expOn.push_back(insideTri(x, y, triAx, triAy, triBx, triBy, triCx, triCy));
            end
        end
    endtask

    task automatic compareScan(input string tag, input int qBase, input int pBase);
        int nq, np, orderErr, onErr;
        nq = qryX.size() - qBase;
        np = pixX.size() - pBase;
        orderErr = 0;
        onErr = 0;
        for (int i = 0; i < expX.size(); i++) begin
            if (i < nq && (qryX[qBase+i] != expX[i] || qryY[qBase+i] != expY[i])) orderErr++;
            if (i < np && (pixX[pBase+i] != expX[i] || pixY[pBase+i] != expY[i])) orderErr++;
            if (i < np && pixOn[pBase+i] != expOn[i]) onErr++;
        end
        checkOutput({tag, " query count"}, 64'(nq), 64'(expX.size()));
        checkOutput({tag, " pixel count"}, 64'(np), 64'(expX.size()));
        checkOutput({tag, " coordinate order errors"}, 64'(orderErr), 64'd0);
        checkOutput({tag, " pix_on errors"}, 64'(onErr), 64'd0);
    endtask

    task automatic waitDone(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (doneCount > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int qBase, pBase, dBase, sBase, startCyc, maxX, maxY;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", 64'({busy, done, err, qry_valid, pix_valid, pix_on,
                                            qry_px, qry_py, pix_x, pix_y}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Scan 1: reference triangle, no stalls
        $display("[TB] scan 1: A=(0,0) B=(5,5) C=(10,0)");
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount;
        applyStimulus(0, 0, 5, 5, 10, 0, startCyc);
        buildExpected();
        @(negedge clk);
        checkOutput("scan1 busy in BBOX", 64'(busy), 64'd1);
        waitDone(dBase, 2000, ok);
        checkOutput("scan1 done seen", 64'(ok), 64'd1);
        checkOutput("scan1 busy low in DONE", 64'(busy), 64'd0);
        checkOutput("scan1 latency", 64'(doneCyc - startCyc), 64'd266);
        checkOutput("scan1 66 queries", 64'(qryX.size() - qBase), 64'd66);
        compareScan("scan1", qBase, pBase);
        checkOutput("scan1 err", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("scan1 single done", 64'(doneCount - dBase), 64'd1);

        // Scan 2: same triangle with stalls on both handshakes
        $display("[TB] scan 2: stalled handshakes");
        qStall = 3; pStall = 2;
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount; sBase = stallChecks;
        applyStimulus(0, 0, 5, 5, 10, 0, startCyc);
        buildExpected();
        waitDone(dBase, 3000, ok);
        checkOutput("scan2 done seen", 64'(ok), 64'd1);
        checkOutput("scan2 latency", 64'(doneCyc - startCyc), 64'd596);
        compareScan("scan2", qBase, pBase);
        checkOutput("scan2 stalled cycles", 64'(stallChecks - sBase), 64'd330);
        checkOutput("scan2 stall stability errors", 64'(stallErrors), 64'd0);
        qStall = 0; pStall = 0;

        // Scan 3: box clipped at the screen corner, with a start pulse while busy
        $display("[TB] scan 3: clipped corner box");
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount;
        applyStimulus(630, 470, 700, 470, 630, 900, startCyc);
        buildExpected();
        repeat (20) @(posedge clk);
        #1;
        ax = '0; ay = '0; bx = 11'd3; by = 10'd3; cx = 11'd1; cy = 10'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(dBase, 2000, ok);
        checkOutput("scan3 done seen", 64'(ok), 64'd1);
        checkOutput("scan3 latency", 64'(doneCyc - startCyc), 64'd402);
        checkOutput("scan3 100 queries", 64'(qryX.size() - qBase), 64'd100);
        compareScan("scan3", qBase, pBase);
        maxX = 0; maxY = 0;
        for (int i = qBase; i < qryX.size(); i++) begin
            if (qryX[i] > maxX) maxX = qryX[i];
            if (qryY[i] > maxY) maxY = qryY[i];
        end
        checkOutput("scan3 max x", 64'(maxX), 64'd639);
        checkOutput("scan3 max y", 64'(maxY), 64'd479);
        repeat (10) @(negedge clk);
        checkOutput("scan3 single done", 64'(doneCount - dBase), 64'd1);
        checkOutput("scan3 idle after", 64'(busy), 64'd0);

        // Scan 4: responder never answers (2,0)
        $display("[TB] scan 4: timeout at (2,0)");
        dropEn = 1'b1; dropX = 2; dropY = 0;
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount;
        applyStimulus(0, 0, 5, 5, 10, 0, startCyc);
        buildExpected();
        waitDone(dBase, 2000, ok);
        checkOutput("scan4 done seen", 64'(ok), 64'd1);
        checkOutput("scan4 latency", 64'(doneCyc - startCyc), 64'd297);
        compareScan("scan4", qBase, pBase);
        checkOutput("scan4 pix_on at (2,0)", 64'(pixOn[pBase+2]), 64'd0);
        checkOutput("scan4 err set", 64'(err), 64'd1);
        dropEn = 1'b0;

        // Scan 5: next start clears err; degenerate single-point triangle
        $display("[TB] scan 5: err clear and point triangle");
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount;
        applyStimulus(3, 3, 3, 3, 3, 3, startCyc);
        buildExpected();
        @(negedge clk);
        checkOutput("scan5 err cleared", 64'(err), 64'd0);
        waitDone(dBase, 200, ok);
        checkOutput("scan5 done seen", 64'(ok), 64'd1);
        checkOutput("scan5 latency", 64'(doneCyc - startCyc), 64'd6);
        compareScan("scan5", qBase, pBase);

        // Scan 6: reset during the 10th query, then a point triangle
        $display("[TB] scan 6: reset mid-scan");
        qBase = qryX.size(); dBase = doneCount;
        applyStimulus(0, 0, 5, 5, 10, 0, startCyc);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (qry_valid === 1'b1 && (qryX.size() - qBase) == 9) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("scan6 reached 10th query", 64'(ok), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("scan6 async reset outputs", 64'({busy, done, err, qry_valid, pix_valid, pix_on,
                                                       qry_px, qry_py, pix_x, pix_y}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("scan6 no done after abort", 64'(doneCount - dBase), 64'd0);
        qBase = qryX.size(); pBase = pixX.size(); dBase = doneCount;
        applyStimulus(3, 3, 3, 3, 3, 3, startCyc);
        buildExpected();
        waitDone(dBase, 200, ok);
        checkOutput("scan6 done seen", 64'(ok), 64'd1);
        compareScan("scan6", qBase, pBase);
        checkOutput("scan6 query x", 64'(qryX[qBase]), 64'd3);
        checkOutput("scan6 query y", 64'(qryY[qBase]), 64'd3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
